multicycle_control: RTL and testbench

- Sequencing FSM for the multi-cycle variant of the MIPS core: a single shared instruction/data memory, an instruction register, and ALU reuse across cycles.
- Drives every datapath mux/enable select each cycle from the current state, the opcode and the ALU zero flag.
- Inserts wait states for a variable-latency memory via a ready handshake, with a timeout guard.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path:
// state enum, opcode constants and datapath select encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXECUTE,
        S_ALU_WB,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP,
        S_EXCEPT,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_EXC    = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that talk to the shared memory and may stall on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory accesses: counts cycles while enabled,
// clears on request, and flags the MEM_TIMEOUT-th consecutive cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(MEM_TIMEOUT - 1);

    logic [TIMER_WIDTH-1:0] count_q, count_d;

    // count_q holds the number of earlier cycles already spent in this state.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM with memory wait states and timeout fault.
// Optional exception state for unknown opcodes: define MULTICYCLE_EXCEPTION_EN.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TIMER_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_err,
    output logic       epc_write
);

    state_t state_q, state_d;
    logic   mem_err_q, mem_err_d;
    logic   timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .clear_i  (state_d != state_q),
        .enable_i (is_mem_state(state_q)),
        .timeout_o(timeout)
    );

    // A ready in the timeout cycle completes the access normally.
    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDI_EXEC;
`ifdef MULTICYCLE_EXCEPTION_EN
                    default:       state_d = S_EXCEPT;
`else
                    default:       state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (timeout) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_EXCEPT:    state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Outputs are forced low while reset is held, even though state reads FETCH.
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = PC_SRC_SEQ;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_err    = mem_err_q;
        epc_write  = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SH2;
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_source = PC_SRC_BRANCH;
                    pc_write  = zero;
                end
                S_JUMP: begin
                    pc_source = PC_SRC_JUMP;
                    pc_write  = 1'b1;
                end
`ifdef MULTICYCLE_EXCEPTION_EN
                S_EXCEPT: begin
                    epc_write = 1'b1;
                    pc_source = PC_SRC_EXC;
                    pc_write  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle expected-output scoreboard.
module tb_multicycle_control;

    typedef enum {
        T_RST, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
        T_EXECUTE, T_ALU_WB, T_ADDI_EXEC, T_ADDI_WB, T_BRANCH, T_JUMP,
        T_EXCEPT, T_HALT
    } tst_e;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_err;
        logic       epc_write;
    } out_t;

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, mem_err, epc_write;
    logic [1:0] pc_source, alu_src_b, alu_op;

    out_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;

    multicycle_control #(
        .MEM_TIMEOUT(4),
        .TIMER_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .i_or_d    (i_or_d),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_write  (ir_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .reg_write (reg_write),
        .mem_err   (mem_err),
        .epc_write (epc_write)
    );

    always #5 clk = ~clk;

    function automatic out_t exp_out(input tst_e st, input logic rdy, input logic z);
        out_t o;
        o = '0;
        case (st)
            T_FETCH: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                o.ir_write = rdy;  o.pc_write  = rdy;
            end
            T_DECODE:    o.alu_src_b = 2'b11;
            T_MEM_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            T_MEM_RD:    begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            T_MEM_WB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            T_MEM_WR:    begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
            T_EXECUTE:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            T_ALU_WB:    begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            T_ADDI_EXEC: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            T_ADDI_WB:   o.reg_write = 1'b1;
            T_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                o.pc_source = 2'b01; o.pc_write = z;
            end
            T_JUMP:      begin o.pc_source = 2'b10; o.pc_write = 1'b1; end
            T_EXCEPT:    begin o.epc_write = 1'b1; o.pc_source = 2'b11; o.pc_write = 1'b1; end
            T_HALT:      o.mem_err = 1'b1;
            default:     ;
        endcase
        return o;
    endfunction

    task automatic check_now(input string tag);
        out_t act, exp;
        act = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a,
               alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, mem_err, epc_write};
        exp = exp_q.pop_front();
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
        checks++;
        assert (!(mem_read === 1'b1 && mem_write === 1'b1)) else begin
            errors++;
            $error("FAIL %s_rdwr: observed rd=%b wr=%b expected not both 1", tag, mem_read, mem_write);
        end
    endtask

    // Drive one cycle's inputs, queue its expectation, compare at the falling edge.
    task automatic cyc(input string tag, input tst_e st, input logic rdy, input logic z);
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(exp_out(st, rdy, z));
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        #1 rst = 1'b0;
        #1 exp_q.push_back(exp_out(T_RST, 1'b0, 1'b0));
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc("rst0", T_RST, 1'b1, 1'b0);
        cyc("rst1", T_RST, 1'b1, 1'b0);
        rst = 1'b1;

        opcode = C_LW;
        cyc("lw_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("lw_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("lw_addr",  T_MEM_ADDR, 1'b1, 1'b0);
        cyc("lw_rd",    T_MEM_RD, 1'b1, 1'b0);
        cyc("lw_wb",    T_MEM_WB, 1'b1, 1'b0);

        opcode = C_SW;
        cyc("sw_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("sw_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("sw_addr",  T_MEM_ADDR, 1'b1, 1'b0);
        cyc("sw_wr",    T_MEM_WR, 1'b1, 1'b0);

        opcode = C_R;
        cyc("r_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("r_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("r_exec",  T_EXECUTE, 1'b1, 1'b0);
        cyc("r_wb",    T_ALU_WB, 1'b1, 1'b0);

        opcode = C_ADDI;
        cyc("addi_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("addi_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("addi_exec",  T_ADDI_EXEC, 1'b1, 1'b0);
        cyc("addi_wb",    T_ADDI_WB, 1'b1, 1'b0);

        opcode = C_BEQ;
        cyc("beq1_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("beq1_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("beq1_br",    T_BRANCH, 1'b1, 1'b1);
        cyc("beq0_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("beq0_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("beq0_br",    T_BRANCH, 1'b1, 1'b0);

        opcode = C_J;
        cyc("j_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("j_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("j_jump",  T_JUMP, 1'b1, 1'b0);

        opcode = C_BAD;
        cyc("fwait1", T_FETCH, 1'b0, 1'b0);
        cyc("fwait2", T_FETCH, 1'b0, 1'b0);
        cyc("fwait3", T_FETCH, 1'b0, 1'b0);
        cyc("fwait4", T_FETCH, 1'b1, 1'b0);
        cyc("bad_dec", T_DECODE, 1'b1, 1'b0);
`ifdef MULTICYCLE_EXCEPTION_EN
        cyc("bad_exc", T_EXCEPT, 1'b1, 1'b0);
`endif

        opcode = C_SW;
        cyc("swl_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("swl_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("swl_addr",  T_MEM_ADDR, 1'b1, 1'b0);
        cyc("swl_wr1",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swl_wr2",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swl_wr3",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swl_wr4",   T_MEM_WR, 1'b1, 1'b0);

        cyc("swt_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("swt_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("swt_addr",  T_MEM_ADDR, 1'b1, 1'b0);
        cyc("swt_wr1",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swt_wr2",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swt_wr3",   T_MEM_WR, 1'b0, 1'b0);
        cyc("swt_wr4",   T_MEM_WR, 1'b0, 1'b0);
        cyc("halt1",     T_HALT, 1'b0, 1'b0);
        cyc("halt2",     T_HALT, 1'b1, 1'b0);
        cyc("halt3",     T_HALT, 1'b1, 1'b1);

        async_reset_check("halt_rst");
        cyc("halt_rst_hold", T_RST, 1'b1, 1'b0);
        rst = 1'b1;

        opcode = C_LW;
        cyc("lwr_fetch", T_FETCH, 1'b1, 1'b0);
        cyc("lwr_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("lwr_addr",  T_MEM_ADDR, 1'b1, 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(exp_out(T_MEM_RD, 1'b0, 1'b0));
        @(negedge clk);
        check_now("lwr_rd");
        async_reset_check("rd_rst");
        rst = 1'b1;
        cyc("post_rst_fetch", T_FETCH, 1'b1, 1'b0);
        opcode = C_R;
        cyc("post_rst_dec",   T_DECODE, 1'b1, 1'b0);
        cyc("post_rst_exec",  T_EXECUTE, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
